dpram_access_ctrl: RTL and testbench
====================================

DPRAM_ACCESS_CTRL -- requirements
Module: dpram_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width (16 words).
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 clk  in  1  rising-edge clock shared with the downstream dual-port RAM.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_a_valid, req_b_valid  in  1  requester X has a command.
REQ-007 req_a_ready, req_b_ready  out  1  command accepted when valid&ready at a rising edge.
REQ-008 req_a_we, req_b_we  in  1  1 = write, 0 = read.
REQ-009 req_a_addr, req_b_addr  in  ADDR_W  word address.
REQ-010 req_a_wdata, req_b_wdata  in  DATA_W  write data.
REQ-011 rsp_a_valid, rsp_b_valid  out  1  one-cycle read-response strobe.
REQ-012 rsp_a_rdata, rsp_b_rdata  out  DATA_W  read data, valid while rsp_x_valid=1.
REQ-013 ram_addr_a, ram_addr_b, ram_data_in_a, ram_data_in_b, ram_we_a, ram_we_b  out  ADDR_W/DATA_W/1  registered RAM port drive.
REQ-014 ram_data_out_a, ram_data_out_b  in  DATA_W  registered RAM read data.
REQ-015 busy  out  1  initialisation in progress.
REQ-016 collision_cnt  out  8  count of cycles in which port B was stalled by a collision.

Function
REQ-017 FSM states INIT and RUN; INIT -> RUN after the last clear write; RUN is terminal until reset.
REQ-018 In RUN, req_a_ready shall be 1 every cycle.
REQ-019 Collision = both valid, req_a_addr==req_b_addr, and (req_a_we|req_b_we); during a collision req_b_ready shall be 0 (port A wins).
REQ-020 Two reads of the same address are not a collision; both are accepted in the same cycle.
REQ-021 On acceptance at edge E0, ram_addr_x/ram_data_in_x/ram_we_x shall carry the command in the following cycle; the RAM captures at E1.
REQ-022 When no command is accepted on port X, ram_we_x shall be 0 and ram_addr_x shall hold its previous value.
REQ-023 Accepted read at E0 -> rsp_x_valid=1 for exactly the cycle after E1 (latency 2), with rsp_x_rdata = ram_data_out_x combinationally.
REQ-024 Writes produce no response; back-to-back accepts every cycle shall be sustained with one response per read.
REQ-025 collision_cnt shall increment by 1 per collision cycle and saturate at 255.
REQ-026 In INIT, req_a_ready=req_b_ready=0, busy=1, and collision_cnt shall not change.

Reset
REQ-027 While rst_n=0: ram_we_a/b=0, ram_addr_a/b=0, ram_data_in_a/b=0, rsp_a/b_valid=0, collision_cnt=0, state=INIT (macro defined) or RUN (macro undefined).
REQ-028 Reset asserted mid-operation shall discard all in-flight commands; no rsp_x_valid shall follow deassertion for pre-reset reads.
REQ-029 Deassertion shall take effect at the first rising edge of clk after rst_n rises.

Configuration
REQ-030 Macro DPRAM_INIT_CLEAR_EN defined: INIT runs 8 cycles, cycle k (k=0..7) writes 0 to address k via port A and address k+8 via port B, then enters RUN with busy=0.
REQ-031 DPRAM_INIT_CLEAR_EN undefined: reset enters RUN directly, busy is tied to 0, and no clear writes are issued.

Verification
REQ-032 Clear check (macro on): release reset -> busy=1 for 8 cycles, ram_we_a/b=1 on addresses 0..7/8..15 with data 0x00, then reads of all addresses return 0x00.
REQ-033 Write-then-read: A writes 0xA5 to addr 3, next cycle A reads addr 3 -> rsp_a_valid 2 cycles after the read accept with rsp_a_rdata=0xA5.
REQ-034 Write collision: A writes 0x11 and B writes 0x22 to addr 7 in the same cycle -> req_b_ready=0 for that cycle, B accepted next cycle, final read of addr 7 = 0x22, collision_cnt=1.
REQ-035 Read/read same address: both read addr 5 -> both accepted at once, collision_cnt unchanged, both rsp_x_rdata equal.
REQ-036 Saturation: hold a write collision for 300 cycles -> collision_cnt stops at 255.
REQ-037 Reset mid-read: accept a read, assert rst_n=0 before its response -> rsp_a_valid stays 0 and all outputs return to reset values.

Source files
------------

// File: rtl/dpram_access_ctrl.sv
// dpram_access_ctrl
//   Arbitrates two requesters (A and B) onto the two ports of a downstream
//   synchronous dual-port RAM. Port A always wins an address conflict that
//   involves a write. RAM drive is registered. Read data is returned two edges
//   after acceptance, directly from the RAM's registered output.
//
//   Optional build macro: DPRAM_INIT_CLEAR_EN
//     defined   : after reset the block spends 8 cycles clearing the RAM
//                 (port A clears 0..7, port B clears 8..15) and holds busy=1.
//     undefined : reset goes straight to RUN and busy is tied low.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_x_valid/ready/we/addr/wdata requester command handshake (x = a, b)
//   rsp_x_valid, rsp_x_rdata        one-cycle read response strobe + data
//   ram_addr_x, ram_data_in_x,
//   ram_we_x                        registered RAM port drive
//   ram_data_out_x                  registered RAM read data
//   busy                            clear sequence in progress
//   collision_cnt                   saturating count of port-B stall cycles
//
// state | meaning
// INIT  | clearing RAM, no requests accepted
// RUN   | normal arbitration (terminal until reset)
module dpram_access_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic              req_a_we,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [DATA_W-1:0] req_a_wdata,

  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic              req_b_we,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [DATA_W-1:0] req_b_wdata,

  output logic              rsp_a_valid,
  output logic [DATA_W-1:0] rsp_a_rdata,
  output logic              rsp_b_valid,
  output logic [DATA_W-1:0] rsp_b_rdata,

  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_data_in_a,
  output logic [DATA_W-1:0] ram_data_in_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_data_out_a,
  input  logic [DATA_W-1:0] ram_data_out_b,

  output logic              busy,
  output logic [7:0]        collision_cnt
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              clr_wr;
  logic              clr_last;
  logic [ADDR_W-1:0] clr_addr_a;
  logic [ADDR_W-1:0] clr_addr_b;

`ifdef DPRAM_INIT_CLEAR_EN
  localparam state_t RST_STATE = ST_INIT;

  // Down-counter: 7 on the first INIT cycle, terminal count 0 on the last.
  // The clear index k runs 0..7, i.e. the bitwise inverse of the count.
  logic [2:0] clr_cnt;
  logic [2:0] clr_k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= 3'd7;
    end else if ((state == ST_INIT) && (clr_cnt != 3'd0)) begin
      clr_cnt <= clr_cnt - 3'd1;
    end
  end

  assign clr_k      = ~clr_cnt;
  assign clr_wr     = (state == ST_INIT);
  assign clr_last   = (state == ST_INIT) && (clr_cnt == 3'd0);
  assign clr_addr_a = ADDR_W'(clr_k);
  assign clr_addr_b = ADDR_W'(clr_k) + ADDR_W'(8);
  assign busy       = (state == ST_INIT);
`else
  localparam state_t RST_STATE = ST_RUN;

  assign clr_wr     = 1'b0;
  assign clr_last   = 1'b0;
  assign clr_addr_a = '0;
  assign clr_addr_b = '0;
  assign busy       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  logic run;
  logic collision;
  logic acc_a;
  logic acc_b;

  // Next state and handshake outputs
  always_comb begin
    state_nxt   = state;
    run         = 1'b0;
    collision   = 1'b0;
    req_a_ready = 1'b0;
    req_b_ready = 1'b0;
    acc_a       = 1'b0;
    acc_b       = 1'b0;

    // Two reads of the same word never conflict; only a write does.
    collision = req_a_valid && req_b_valid &&
                (req_a_addr == req_b_addr) &&
                (req_a_we || req_b_we);

    case (state)
      ST_INIT: begin
        if (clr_last) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        run         = 1'b1;
        req_a_ready = 1'b1;
        req_b_ready = !collision;
      end
      default: begin
        state_nxt = RST_STATE;
      end
    endcase

    acc_a = req_a_valid && req_a_ready;
    acc_b = req_b_valid && req_b_ready;
  end

  // Registered RAM drive. Address and write data hold when idle so the RAM
  // port stays quiet; only the write enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we_a      <= 1'b0;
      ram_we_b      <= 1'b0;
      ram_addr_a    <= '0;
      ram_addr_b    <= '0;
      ram_data_in_a <= '0;
      ram_data_in_b <= '0;
    end else if (clr_wr) begin
      ram_we_a      <= 1'b1;
      ram_we_b      <= 1'b1;
      ram_addr_a    <= clr_addr_a;
      ram_addr_b    <= clr_addr_b;
      ram_data_in_a <= '0;
      ram_data_in_b <= '0;
    end else begin
      ram_we_a <= acc_a && req_a_we;
      ram_we_b <= acc_b && req_b_we;
      if (acc_a) begin
        ram_addr_a    <= req_a_addr;
        ram_data_in_a <= req_a_wdata;
      end
      if (acc_b) begin
        ram_addr_b    <= req_b_addr;
        ram_data_in_b <= req_b_wdata;
      end
    end
  end

  // Read response pipeline: stage 1 tracks the cycle the RAM sees the read,
  // stage 2 lines up with the RAM's registered output.
  logic rd_pend_a;
  logic rd_pend_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_a   <= 1'b0;
      rd_pend_b   <= 1'b0;
      rsp_a_valid <= 1'b0;
      rsp_b_valid <= 1'b0;
    end else begin
      rd_pend_a   <= acc_a && !req_a_we;
      rd_pend_b   <= acc_b && !req_b_we;
      rsp_a_valid <= rd_pend_a;
      rsp_b_valid <= rd_pend_b;
    end
  end

  assign rsp_a_rdata = ram_data_out_a;
  assign rsp_b_rdata = ram_data_out_b;

  // Saturating stall counter; frozen outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_cnt <= 8'd0;
    end else if (run && collision && (collision_cnt != 8'hFF)) begin
      collision_cnt <= collision_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Testbench for dpram_access_ctrl: directed vectors with a queue-based
// scoreboard for read responses and direct checks of RAM drive / status.
module tb_dpram_access_ctrl;

  localparam logic [7:0] FILL = 8'hEE;
`ifdef DPRAM_INIT_CLEAR_EN
  localparam logic [7:0] UNWR = 8'h00;
  localparam logic       BUSY_RST = 1'b1;
`else
  localparam logic [7:0] UNWR = FILL;
  localparam logic       BUSY_RST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a_valid, req_a_ready, req_a_we;
  logic [3:0] req_a_addr;
  logic [7:0] req_a_wdata;
  logic       req_b_valid, req_b_ready, req_b_we;
  logic [3:0] req_b_addr;
  logic [7:0] req_b_wdata;
  logic       rsp_a_valid, rsp_b_valid;
  logic [7:0] rsp_a_rdata, rsp_b_rdata;
  logic [3:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_data_in_a, ram_data_in_b;
  logic       ram_we_a, ram_we_b;
  logic [7:0] ram_data_out_a, ram_data_out_b;
  logic       busy;
  logic [7:0] collision_cnt;

  dpram_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_we(req_a_we),
    .req_a_addr(req_a_addr), .req_a_wdata(req_a_wdata),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_we(req_b_we),
    .req_b_addr(req_b_addr), .req_b_wdata(req_b_wdata),
    .rsp_a_valid(rsp_a_valid), .rsp_a_rdata(rsp_a_rdata),
    .rsp_b_valid(rsp_b_valid), .rsp_b_rdata(rsp_b_rdata),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_data_in_a(ram_data_in_a), .ram_data_in_b(ram_data_in_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_data_out_a(ram_data_out_a), .ram_data_out_b(ram_data_out_b),
    .busy(busy), .collision_cnt(collision_cnt)
  );

  always #5 clk = ~clk;

  // Dual-port RAM model with registered read, preloaded on the first edge.
  logic [7:0] mem [16];
  logic       mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= FILL;
      mem_loaded <= 1'b1;
    end else begin
      if (ram_we_a) mem[ram_addr_a] <= ram_data_in_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_data_in_b;
    end
    ram_data_out_a <= mem[ram_addr_a];
    ram_data_out_b <= mem[ram_addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rsp_a_valid) begin
          if (qa.size() == 0) begin
            chk("rsp_a_unexpected", 32'(rsp_a_valid), 32'd0);
          end else begin
            e = qa.pop_front();
            chk("rsp_a_rdata", 32'(rsp_a_rdata), 32'(e.data));
            chk("rsp_a_cycle", 32'(cyc), 32'(e.due));
          end
        end else if (qa.size() != 0 && qa[0].due <= cyc) begin
          e = qa.pop_front();
          chk("rsp_a_missing", 32'(rsp_a_valid), 32'd1);
        end
        if (rsp_b_valid) begin
          if (qb.size() == 0) begin
            chk("rsp_b_unexpected", 32'(rsp_b_valid), 32'd0);
          end else begin
            e = qb.pop_front();
            chk("rsp_b_rdata", 32'(rsp_b_rdata), 32'(e.data));
            chk("rsp_b_cycle", 32'(cyc), 32'(e.due));
          end
        end else if (qb.size() != 0 && qb[0].due <= cyc) begin
          e = qb.pop_front();
          chk("rsp_b_missing", 32'(rsp_b_valid), 32'd1);
        end
      end
    end
  endtask

  // Drive one cycle of commands; reads that will be accepted go to the scoreboard.
  task automatic issue(input logic av, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                       input logic bv, input logic bw, input logic [3:0] ba, input logic [7:0] bd,
                       input logic exp_b_rdy, input logic [7:0] exp_ra, input logic [7:0] exp_rb);
    @(negedge clk);
    req_a_valid = av; req_a_we = aw; req_a_addr = aa; req_a_wdata = ad;
    req_b_valid = bv; req_b_we = bw; req_b_addr = ba; req_b_wdata = bd;
    #1;
    if (av) chk("req_a_ready", 32'(req_a_ready), 32'd1);
    if (bv) chk("req_b_ready", 32'(req_b_ready), 32'(exp_b_rdy));
    if (av && !aw) qa.push_back('{cyc + 2, exp_ra});
    if (bv && !bw && exp_b_rdy) qb.push_back('{cyc + 2, exp_rb});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      issue(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 8'd0, 8'd0);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_release", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a_valid = 1'b0; req_a_we = 1'b0; req_a_addr = '0; req_a_wdata = '0;
    req_b_valid = 1'b0; req_b_we = 1'b0; req_b_addr = '0; req_b_wdata = '0;
    fork monitor(); join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ram_we_a", 32'(ram_we_a), 32'd0);
    chk("rst_ram_we_b", 32'(ram_we_b), 32'd0);
    chk("rst_ram_addr_a", 32'(ram_addr_a), 32'd0);
    chk("rst_ram_data_in_b", 32'(ram_data_in_b), 32'd0);
    chk("rst_rsp_valid", 32'({rsp_a_valid, rsp_b_valid}), 32'd0);
    chk("rst_collision_cnt", 32'(collision_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'(BUSY_RST));
    rst_n = 1'b1;

`ifdef DPRAM_INIT_CLEAR_EN
    // Clear sequence: k-th edge drives address k / k+8 with zero data
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("clr_we", 32'({ram_we_a, ram_we_b}), 32'd3);
      chk("clr_addr_a", 32'(ram_addr_a), 32'(k));
      chk("clr_addr_b", 32'(ram_addr_b), 32'(k + 8));
      chk("clr_data", 32'({ram_data_in_a, ram_data_in_b}), 32'd0);
      chk("clr_busy", 32'(busy), 32'(k < 7));
    end
    for (int k = 0; k < 8; k++)
      issue(1'b1, 1'b0, 4'(k), 8'd0, 1'b1, 1'b0, 4'(k + 8), 8'd0, 1'b1, 8'h00, 8'h00);
    idle(4);
`else
    @(posedge clk); #1;
    chk("run_a_ready", 32'(req_a_ready), 32'd1);
    chk("run_busy", 32'(busy), 32'd0);
`endif

    // Write-then-read on port A
    issue(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 8'd0, 8'd0);
    @(posedge clk); #1;
    chk("wr_ram_we_a", 32'(ram_we_a), 32'd1);
    chk("wr_ram_addr_a", 32'(ram_addr_a), 32'd3);
    chk("wr_ram_data_in_a", 32'(ram_data_in_a), 32'hA5);
    issue(1'b1, 1'b0, 4'd3, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 8'hA5, 8'd0);
    idle(1);
    @(posedge clk); #1;
    chk("idle_ram_we_a", 32'(ram_we_a), 32'd0);
    chk("idle_ram_addr_hold", 32'(ram_addr_a), 32'd3);
    idle(3);

    // Write collision on address 7: A wins, B retries next cycle
    issue(1'b1, 1'b1, 4'd7, 8'h11, 1'b1, 1'b1, 4'd7, 8'h22, 1'b0, 8'd0, 8'd0);
    @(posedge clk); #1;
    chk("coll_cnt_1", 32'(collision_cnt), 32'd1);
    chk("coll_ram_we_b", 32'(ram_we_b), 32'd0);
    issue(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 4'd7, 8'h22, 1'b1, 8'd0, 8'd0);
    issue(1'b1, 1'b0, 4'd7, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 8'h22, 8'd0);
    idle(4);
    chk("coll_cnt_keep", 32'(collision_cnt), 32'd1);

    // Read/read on the same address is not a collision
    issue(1'b1, 1'b1, 4'd5, 8'h5C, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 8'd0, 8'd0);
    issue(1'b1, 1'b0, 4'd5, 8'd0, 1'b1, 1'b0, 4'd5, 8'd0, 1'b1, 8'h5C, 8'h5C);
    idle(4);
    chk("rr_coll_cnt", 32'(collision_cnt), 32'd1);

    // Back-to-back traffic: writes then reads every cycle on both ports
    for (int i = 0; i < 4; i++)
      issue(1'b1, 1'b1, 4'(12 + i), 8'(8'h40 + i), 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++)
      issue(1'b1, 1'b0, 4'(12 + i), 8'd0, 1'b1, 1'b0, 4'(8 + i), 8'd0, 1'b1, 8'(8'h40 + i), UNWR);
    idle(4);

    // Saturation: held write collision on address 9
    for (int i = 0; i < 253; i++)
      issue(1'b1, 1'b1, 4'd9, 8'h33, 1'b1, 1'b1, 4'd9, 8'h44, 1'b0, 8'd0, 8'd0);
    @(posedge clk); #1;
    chk("sat_cnt_254", 32'(collision_cnt), 32'd254);
    for (int i = 0; i < 47; i++)
      issue(1'b1, 1'b1, 4'd9, 8'h33, 1'b1, 1'b1, 4'd9, 8'h44, 1'b0, 8'd0, 8'd0);
    @(posedge clk); #1;
    chk("sat_cnt_255", 32'(collision_cnt), 32'd255);
    idle(4);

    // Reset while a read is in flight
    issue(1'b1, 1'b0, 4'd3, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 8'd0, 8'd0);
    void'(qa.pop_back());          // this read must never answer
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_a_valid = 1'b0;
    #1;
    chk("mid_rst_ram_we", 32'({ram_we_a, ram_we_b}), 32'd0);
    chk("mid_rst_ram_addr_a", 32'(ram_addr_a), 32'd0);
    chk("mid_rst_ram_data_in_a", 32'(ram_data_in_a), 32'd0);
    chk("mid_rst_rsp_valid", 32'({rsp_a_valid, rsp_b_valid}), 32'd0);
    chk("mid_rst_coll_cnt", 32'(collision_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_a_valid), 32'd0);
    end
    wait_ready();
`ifdef DPRAM_INIT_CLEAR_EN
    issue(1'b1, 1'b0, 4'd3, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 8'h00, 8'd0);
`else
    issue(1'b1, 1'b0, 4'd3, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 8'hA5, 8'd0);
`endif
    idle(5);

    chk("sb_drain_a", 32'(qa.size()), 32'd0);
    chk("sb_drain_b", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
